// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DRAIN
  } fetch_state_e;

  localparam logic [31:0] PC_INC       = 32'd4;
  localparam logic [31:0] PC_PLUS8_OFS = 32'd8;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_queue.sv
// Parameterized-depth FIFO of {addr, instr} fetch entries with synchronous flush.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  fetch_entry_t               data_i,
  input  logic                       pop_i,
  output fetch_entry_t               head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             empty, full, do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i & ~empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage has no reset; entries are only observed once count_q marks them valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: PC sequencing, memory requests, redirect flush/drain.
// Define IFETCH_PREFETCH_EN for a 2-deep queue with 2 outstanding requests.
module ifetch_stage
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        PCSrcW,
  input  logic [31:0] ResultW,
  input  logic        BranchTakenE,
  input  logic [31:0] BranchTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrF,
  output logic [31:0] PCPlus8,
  output logic        ValidF
);

`ifdef IFETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam int QCNT_W = $clog2(DEPTH + 1);
  // In-flight count covers stale requests still draining plus live ones behind them.
  localparam int OCNT_W = $clog2(2 * DEPTH + 1);

  logic [31:0]       pc_q, pc_d, rsp_pc_q, rsp_pc_d;
  logic [OCNT_W-1:0] out_q, out_d, drop_q, drop_d, live, occupancy;
  fetch_state_e      state_q, state_d;
  logic [QCNT_W-1:0] q_count;
  fetch_entry_t      head, push_entry;
  logic              redirect, grant, rsp, stale_rsp, push, pop;
  logic [31:0]       redirect_target;

  assign redirect        = PCSrcW | BranchTakenE;
  assign redirect_target = (PCSrcW ? ResultW : BranchTargetE) & ~32'h3;

  assign live      = out_q - drop_q;
  assign occupancy = OCNT_W'(q_count) + live;
  assign imem_req  = reset && !redirect && (occupancy < OCNT_W'(DEPTH))
                     && (out_q < OCNT_W'(2 * DEPTH));
  assign imem_addr = pc_q;
  assign grant     = imem_req & imem_gnt;

  assign rsp        = imem_rvalid & (out_q != '0);
  assign stale_rsp  = rsp & (drop_q != '0);
  assign push       = rsp & ~stale_rsp & ~redirect;
  assign pop        = ValidF & ~StallF;
  assign push_entry = '{addr: rsp_pc_q, instr: imem_rdata};

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    out_d    = out_q + OCNT_W'(grant) - OCNT_W'(rsp);
    drop_d   = drop_q;
    state_d  = state_q;

    if (redirect) begin
      pc_d     = redirect_target;
      rsp_pc_d = redirect_target;
      drop_d   = out_d;
    end else begin
      if (grant)     pc_d     = pc_q + PC_INC;
      if (push)      rsp_pc_d = rsp_pc_q + PC_INC;
      if (stale_rsp) drop_d   = drop_q - OCNT_W'(1);
    end

    case (state_q)
      IDLE:  if (grant) state_d = BUSY;
      BUSY: begin
        if (redirect && out_d != '0) state_d = DRAIN;
        else if (out_d == '0)        state_d = IDLE;
      end
      DRAIN: if (drop_d == '0) state_d = (out_d != '0) ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
      state_q  <= IDLE;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      state_q  <= state_d;
    end
  end

  ifetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk     (clk),
    .rst_n   (reset),
    .flush_i (redirect),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (q_count)
  );

  assign ValidF  = (q_count != '0);
  assign InstrF  = ValidF ? head.instr : '0;
  assign PCPlus8 = (ValidF ? head.addr : pc_q) + PC_PLUS8_OFS;

endmodule
